// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, bounce
// direction constants and the per-mode seed pattern.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Returned 32 bits wide; callers size-cast to their LED width.
  function automatic logic [31:0] seed(input logic [1:0] mode, input int unsigned width);
    logic [31:0] s;
    case (mode)
      MODE_ROR:   s = 32'd1 << (width - 1);
      MODE_COUNT: s = 32'd0;
      default:    s = 32'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step prescaler: emits one step strobe every DIV enabled clock cycles.
// The count freezes while en is low so no step is lost or duplicated.
module led_step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic step
);

  localparam int unsigned   CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign step = en && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= step ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: rotate-left, rotate-right, bounce and
// binary count, stepped by a prescaler, with registered tick/wrap strobes.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_led;
  logic [1:0]       r_mode_q;
  logic             r_dir;
  logic             r_tick;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_led;
  logic [WIDTH-1:0] w_seed_new;
  logic [WIDTH-1:0] w_seed_cur;
  logic             w_next_dir;
  logic             w_next_wrap;
  logic             w_onehot;
  logic             w_step;
  logic             w_mode_chg;
  logic             w_presc_rst;

  assign w_mode_chg  = (mode != r_mode_q);
  // A mode change restarts the prescale interval through its sync reset.
  assign w_presc_rst = reset & ~w_mode_chg;

  led_step_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(w_presc_rst),
    .en   (en),
    .step (w_step)
  );

  always_comb begin
    w_seed_new  = WIDTH'(seed(mode, WIDTH));
    w_seed_cur  = WIDTH'(seed(r_mode_q, WIDTH));
    w_onehot    = (r_led != '0) && ((r_led & (r_led - ONE)) == '0);
    w_next_led  = r_led;
    w_next_dir  = r_dir;
    w_next_wrap = 1'b0;
    if (r_mode_q != MODE_COUNT && !w_onehot) begin
      w_next_led = w_seed_cur;
      w_next_dir = DIR_UP;
    end else begin
      case (r_mode_q)
        MODE_ROL: begin
          w_next_led  = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
          w_next_wrap = r_led[WIDTH-1];
        end
        MODE_ROR: begin
          w_next_led  = {r_led[0], r_led[WIDTH-1:1]};
          w_next_wrap = r_led[0];
        end
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (r_led[WIDTH-1]) begin
              w_next_led  = r_led >> 1;
              w_next_dir  = DIR_DOWN;
              w_next_wrap = 1'b1;
            end else begin
              w_next_led = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_next_led  = r_led << 1;
              w_next_dir  = DIR_UP;
              w_next_wrap = 1'b1;
            end else begin
              w_next_led = r_led >> 1;
            end
          end
        end
        default: begin
          w_next_led  = r_led + ONE;
          w_next_wrap = &r_led;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led    <= ONE;
      r_dir    <= DIR_UP;
      r_mode_q <= MODE_ROL;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_mode_q <= mode;
      if (w_mode_chg) begin
        r_led  <= w_seed_new;
        r_dir  <= DIR_UP;
        r_tick <= 1'b0;
        r_wrap <= 1'b0;
      end else if (w_step) begin
        r_led  <= w_next_led;
        r_dir  <= w_next_dir;
        r_tick <= 1'b1;
        r_wrap <= w_next_wrap;
      end else begin
        r_tick <= 1'b0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign led  = r_led;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen using three instances:
// 4 LEDs with DIV=1, 4 LEDs with DIV=3, 8 LEDs with DIV=5.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [3:0] led_a, led_b;
  logic [7:0] led_c;
  logic       tick_a, wrap_a, tick_b, wrap_b, tick_c, wrap_c;

  int n_assert = 0;
  int n_fail   = 0;

  led_pattern_gen #(.WIDTH(4), .DIV(1)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .mode(mode_a),
    .led(led_a), .tick(tick_a), .wrap(wrap_a)
  );

  led_pattern_gen #(.WIDTH(4), .DIV(3)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .mode(mode_b),
    .led(led_b), .tick(tick_b), .wrap(wrap_b)
  );

  led_pattern_gen #(.WIDTH(8), .DIV(5)) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .mode(mode_c),
    .led(led_c), .tick(tick_c), .wrap(wrap_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input string tag, input logic [3:0] e_led, input logic e_tick, input logic e_wrap);
    cyc();
    chk({tag, "_led"},  32'(led_a),  32'(e_led));
    chk({tag, "_tick"}, 32'(tick_a), 32'(e_tick));
    chk({tag, "_wrap"}, 32'(wrap_a), 32'(e_wrap));
  endtask

  task automatic step_b(input string tag, input logic [3:0] e_led, input logic e_tick, input logic e_wrap);
    cyc();
    chk({tag, "_led"},  32'(led_b),  32'(e_led));
    chk({tag, "_tick"}, 32'(tick_b), 32'(e_tick));
    chk({tag, "_wrap"}, 32'(wrap_b), 32'(e_wrap));
  endtask

  task automatic step_c(input string tag, input logic [7:0] e_led, input logic e_tick, input logic e_wrap);
    cyc();
    chk({tag, "_led"},  32'(led_c),  32'(e_led));
    chk({tag, "_tick"}, 32'(tick_c), 32'(e_tick));
    chk({tag, "_wrap"}, 32'(wrap_c), 32'(e_wrap));
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; mode_a = 2'd0;
    rst_b = 1'b0; en_b = 1'b0; mode_b = 2'd0;
    rst_c = 1'b0; en_c = 1'b0; mode_c = 2'd0;
    cyc();
    cyc();
    chk("rst_led_a",  32'(led_a),  32'h1);
    chk("rst_tick_a", 32'(tick_a), 32'h0);
    chk("rst_wrap_a", 32'(wrap_a), 32'h0);
    chk("rst_led_c",  32'(led_c),  32'h1);

    // rotate-left, one step per cycle
    rst_a = 1'b1; en_a = 1'b1;
    step_a("t1_s1", 4'b0010, 1'b1, 1'b0);
    step_a("t1_s2", 4'b0100, 1'b1, 1'b0);
    step_a("t1_s3", 4'b1000, 1'b1, 1'b0);
    step_a("t1_s4", 4'b0001, 1'b1, 1'b1);

    // bounce
    mode_a = 2'd2;
    step_a("t3_seed", 4'b0001, 1'b0, 1'b0);
    step_a("t3_s1",   4'b0010, 1'b1, 1'b0);
    step_a("t3_s2",   4'b0100, 1'b1, 1'b0);
    step_a("t3_s3",   4'b1000, 1'b1, 1'b0);
    step_a("t3_s4",   4'b0100, 1'b1, 1'b1);
    step_a("t3_s5",   4'b0010, 1'b1, 1'b0);
    step_a("t3_s6",   4'b0001, 1'b1, 1'b0);
    step_a("t3_s7",   4'b0010, 1'b1, 1'b1);

    // binary count, full wrap, then switch to rotate-right mid-count
    mode_a = 2'd3;
    step_a("t4_seed", 4'b0000, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) step_a("t4_cnt", 4'(i), 1'b1, 1'b0);
    step_a("t4_wrap", 4'b0000, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) step_a("t4_cnt2", 4'(i), 1'b1, 1'b0);
    mode_a = 2'd1;
    step_a("t4_ror_seed", 4'b1000, 1'b0, 1'b0);
    step_a("t4_ror_s1",   4'b0100, 1'b1, 1'b0);
    step_a("t4_ror_s2",   4'b0010, 1'b1, 1'b0);
    step_a("t4_ror_s3",   4'b0001, 1'b1, 1'b0);
    step_a("t4_ror_s4",   4'b1000, 1'b1, 1'b1);

    // corrupted pattern recovers to the seed without a wrap
    mode_a = 2'd0;
    step_a("t6_seed", 4'b0001, 1'b0, 1'b0);
    en_a = 1'b0;
    force u_a.r_led = 4'b0110;
    #1;
    release u_a.r_led;
    chk("t6_forced", 32'(led_a), 32'h6);
    en_a = 1'b1;
    step_a("t6_recover", 4'b0001, 1'b1, 1'b0);
    step_a("t6_after",   4'b0010, 1'b1, 1'b0);

    // DIV=3 with enable gaps
    rst_b = 1'b1; en_b = 1'b1;
    step_b("t2_e1", 4'b0001, 1'b0, 1'b0);
    step_b("t2_e2", 4'b0001, 1'b0, 1'b0);
    en_b = 1'b0;
    step_b("t2_off1", 4'b0001, 1'b0, 1'b0);
    step_b("t2_off2", 4'b0001, 1'b0, 1'b0);
    en_b = 1'b1;
    step_b("t2_step", 4'b0010, 1'b1, 1'b0);
    en_b = 1'b0;
    step_b("t2_hold", 4'b0010, 1'b0, 1'b0);

    // DIV=5, 8 LEDs: mode change coincident with a step, then mid-prescale reset
    rst_c = 1'b1; en_c = 1'b1;
    for (int i = 0; i < 4; i++) step_c("t5_pre", 8'h01, 1'b0, 1'b0);
    step_c("t5_step", 8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step_c("t5_pre2", 8'h02, 1'b0, 1'b0);
    chk("t5_cnt4", 32'(u_c.u_prescaler.r_count), 32'd4);
    mode_c = 2'd1;
    step_c("t5_modechg", 8'h80, 1'b0, 1'b0);
    chk("t5_cnt_clr", 32'(u_c.u_prescaler.r_count), 32'd0);
    for (int i = 0; i < 4; i++) step_c("t5_pre3", 8'h80, 1'b0, 1'b0);
    step_c("t5_ror", 8'h40, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_c("t5_pre4", 8'h40, 1'b0, 1'b0);
    chk("t5_cnt3", 32'(u_c.u_prescaler.r_count), 32'd3);
    rst_c = 1'b0;
    step_c("t5_rst", 8'h01, 1'b0, 1'b0);
    chk("t5_rst_cnt", 32'(u_c.u_prescaler.r_count), 32'd0);
    rst_c = 1'b1;
    step_c("t5_rel_seed", 8'h80, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the reconfigurable LED partition. It replaces the fixed 4-bit, one-direction rotators with a single block that supports:
- WIDTH LEDs.
- An internal step prescaler.
- Four run-time modes: rotate-left, rotate-right, bounce and binary count.

It sits between the static-region enable/mode registers and the board LED pins. It exports step and wrap strobes for status logic.

Parameters:
- WIDTH, 8, number of LEDs; legal range 2..32.
- DIV, 1, number of enabled clk cycles per pattern step; legal range 1..2^16. DIV=1 means one step per enabled cycle.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- en  input  1  step enable; prescaler and pattern hold while low.
- mode  input  2  0=rotate-left, 1=rotate-right, 2=bounce, 3=binary count.
- led  output  WIDTH  current pattern, driven directly from a register.
- tick  output  1  high for one cycle in the first cycle a new stepped value is on led.
- wrap  output  1  high together with tick when that step was a wrap or reversal.

Behaviour:
- Reset (reset==0 at a clk edge):
  - led = 1 (bit0 set).
  - Prescaler count = 0, dir = up, mode_q = 0.
  - tick = 0, wrap = 0.
  - Reset overrides every other input, including mid-prescale and mid-bounce.
- Prescaler:
  - Count width is max(1, clog2(DIV)).
  - step = en && (count == DIV-1).
  - When en is high: count increments; on step it clears to 0.
  - When en is low: count holds.
- Mode handling:
  - mode is registered into mode_q every cycle.
  - If mode != mode_q at an edge, that edge does the following, regardless of en or step:
    - led loads the seed for the new mode: bit0 for modes 0 and 2; bit WIDTH-1 for mode 1; all-zero for mode 3.
    - count clears, dir is set to up, tick = 0, wrap = 0.
  - A mode change has priority over a coincident step.
- Step actions (one per step, no mode change):
  - Mode 0, rotate-left: led <= {led[W-2:0], led[W-1]}. wrap=1 when led[W-1] was set.
  - Mode 1, rotate-right: led <= {led[0], led[W-1:1]}. wrap=1 when led[0] was set.
  - Mode 2, bounce:
    - dir up: if led[W-1] is set, led <= led>>1, dir <= down, wrap=1; otherwise led <= led<<1.
    - dir down: mirror image, reversing at led[0].
    - The period is 2*WIDTH-2 steps.
  - Mode 3, binary count: led <= led+1, modulo 2^WIDTH. wrap=1 on the all-ones to zero step.
- Pattern recovery: in modes 0-2, if led is not one-hot at a step, led loads the mode seed, dir is set to up, and wrap=0.
- tick and wrap:
  - Both are registered.
  - tick is 1 exactly in the cycle after each step edge. wrap qualifies it.
  - Both are 0 in every other cycle.
- en deasserted mid-prescale: the count is frozen and resumes where it stopped; no step is lost or duplicated.
- Latency: led changes on the same edge where step is true, so the first step happens DIV enabled cycles after reset release.

Decomposition:
- Shared package, led_pattern_pkg, holds:
  - Mode encodings MODE_ROL=0, MODE_ROR=1, MODE_BOUNCE=2, MODE_COUNT=3.
  - DIR_UP/DIR_DOWN constants.
  - A seed-selection function seed(mode, WIDTH).
- One sub-module, led_step_prescaler (parameter DIV; ports clk, reset, en, step). It holds the counter and the step decode and is reused by other LED partitions.
- The pattern register, dir flag and mode register live in the top.

Test Plan:
1. WIDTH=4, DIV=1, mode=0, en=1 after reset → led 0001,0010,0100,1000,0001. tick high every cycle after the first step; wrap high only with the 1000→0001 step.
2. WIDTH=4, DIV=3, mode=0, en toggled 1,1,0,0,1 → exactly one step after the third enabled cycle (led 0001→0010). Nothing changes while en=0.
3. WIDTH=4, DIV=1, mode=2 → led sequence 0001,0010,0100,1000,0100,0010,0001,0010. wrap on 1000→0100 and on 0001→0010.
4. WIDTH=4, DIV=1, mode=3 → count 0000..1111 then 0000 with wrap=1. Switching to mode=1 mid-count loads 1000 with no tick, then steps to 0100.
5. WIDTH=8, DIV=5, mode change coincident with step → led equals the new seed, count=0, tick=0. reset=0 asserted at count=3 → led=00000001, tick=0, wrap=0 on the next edge.
6. WIDTH=4, mode=0, force led to 0110 via backdoor → the next step yields 0001 with wrap=0.
